// File: rtl/issue_scoreboard_if.sv
// Issue-stage bundle between the instruction pair source and the dual-issue scoreboard.
interface issue_scoreboard_if;
  logic [31:0] instr_a_i;
  logic        valid_a_i;
  logic [31:0] instr_b_i;
  logic        valid_b_i;
  logic        prio_i;
  logic        flush_i;
  logic        issue_a_o;
  logic        issue_b_o;
  logic        stall_en_o;
  logic [15:0] stall_cnt_o;

  modport master (
    output instr_a_i, valid_a_i, instr_b_i, valid_b_i, prio_i, flush_i,
    input  issue_a_o, issue_b_o, stall_en_o, stall_cnt_o
  );

  modport slave (
    input  instr_a_i, valid_a_i, instr_b_i, valid_b_i, prio_i, flush_i,
    output issue_a_o, issue_b_o, stall_en_o, stall_cnt_o
  );
endinterface

// File: rtl/issue_scoreboard.sv
// Dual-issue scoreboard: per-register busy countdowns, in-order pair grant logic,
// and a saturating stall-cycle counter.
module issue_scoreboard #(
  parameter int unsigned ALU_LAT  = 2,
  parameter int unsigned LOAD_LAT = 3,
  parameter int unsigned CNT_W    = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  issue_scoreboard_if.slave bus
);

  localparam int unsigned NREG   = 32;
  localparam int unsigned STALL_W = 16;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_OP    = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [CNT_W-1:0]   ALU_L    = CNT_W'(ALU_LAT);
  localparam logic [CNT_W-1:0]   LOAD_L   = CNT_W'(LOAD_LAT);
  localparam logic [STALL_W-1:0] STALL_MAX = '1;

  typedef struct packed {
    logic       wr;
    logic       rd1;
    logic       rd2;
    logic       mem;
    logic       load;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } dec_t;

  // Register-use classification by major opcode; unknown opcodes touch nothing.
  function automatic dec_t decode(input logic [31:0] ins);
    dec_t d;
    d      = '0;
    d.rd   = ins[11:7];
    d.rs1  = ins[19:15];
    d.rs2  = ins[24:20];
    case (ins[6:0])
      OP_LUI, OP_AUIPC: d.wr = 1'b1;
      OP_IMM: begin
        d.wr  = 1'b1;
        d.rd1 = 1'b1;
      end
      OP_OP: begin
        d.wr  = 1'b1;
        d.rd1 = 1'b1;
        d.rd2 = 1'b1;
      end
      OP_LOAD: begin
        d.wr   = 1'b1;
        d.rd1  = 1'b1;
        d.mem  = 1'b1;
        d.load = 1'b1;
      end
      OP_STORE: begin
        d.rd1 = 1'b1;
        d.rd2 = 1'b1;
        d.mem = 1'b1;
      end
      default: d = d;
    endcase
    return d;
  endfunction

  logic [CNT_W-1:0]   busy [NREG];
  logic [STALL_W-1:0] stall_cnt;

  dec_t dec_a, dec_b, dec_o, dec_y;
  logic ok_a, ok_b, ok_o, ok_y;
  logic valid_o, valid_y;
  logic grant_o, grant_y;
  logic raw, waw, lsu;
  logic issue_a, issue_b, stall_en;
  logic wr_a, wr_b;
  logic [CNT_W-1:0] lat_a, lat_b;

  assign dec_a = decode(bus.instr_a_i);
  assign dec_b = decode(bus.instr_b_i);

  // Source readiness against the registered scoreboard.
  always_comb begin
    ok_a = (!dec_a.rd1 || (busy[dec_a.rs1] == '0)) &&
           (!dec_a.rd2 || (busy[dec_a.rs2] == '0));
    ok_b = (!dec_b.rd1 || (busy[dec_b.rs1] == '0)) &&
           (!dec_b.rd2 || (busy[dec_b.rs2] == '0));
  end

  // Map lanes onto older/younger roles.
  always_comb begin
    if (bus.prio_i) begin
      dec_o   = dec_b;
      dec_y   = dec_a;
      ok_o    = ok_b;
      ok_y    = ok_a;
      valid_o = bus.valid_b_i;
      valid_y = bus.valid_a_i;
    end else begin
      dec_o   = dec_a;
      dec_y   = dec_b;
      ok_o    = ok_a;
      ok_y    = ok_b;
      valid_o = bus.valid_a_i;
      valid_y = bus.valid_b_i;
    end
  end

  // Intra-pair hazards; writes to x0 never create a dependence.
  always_comb begin
    raw = dec_o.wr && (dec_o.rd != 5'd0) &&
          ((dec_y.rd1 && (dec_y.rs1 == dec_o.rd)) ||
           (dec_y.rd2 && (dec_y.rs2 == dec_o.rd)));
    waw = dec_o.wr && dec_y.wr && (dec_o.rd != 5'd0) && (dec_o.rd == dec_y.rd);
    lsu = dec_o.mem && dec_y.mem;
  end

  always_comb begin
    grant_o = valid_o && ok_o && !bus.flush_i && !rst_i;
    grant_y = (grant_o || !valid_o) && valid_y && ok_y &&
              !(valid_o && (raw || waw || lsu)) &&
              !bus.flush_i && !rst_i;
    issue_a = bus.prio_i ? grant_y : grant_o;
    issue_b = bus.prio_i ? grant_o : grant_y;
    stall_en = !bus.flush_i && !rst_i &&
               ((bus.valid_a_i && !issue_a) || (bus.valid_b_i && !issue_b));
  end

  always_comb begin
    wr_a  = issue_a && dec_a.wr;
    wr_b  = issue_b && dec_b.wr;
    lat_a = dec_a.load ? LOAD_L : ALU_L;
    lat_b = dec_b.load ? LOAD_L : ALU_L;
  end

  // Busy countdowns: a fresh grant reloads, otherwise count toward ready.
  always_ff @(posedge clk_i) begin
    for (int r = 0; r < NREG; r++) begin
      if (rst_i || (r == 0)) begin
        busy[r] <= '0;
      end else if (wr_a && (dec_a.rd == 5'(r))) begin
        busy[r] <= lat_a;
      end else if (wr_b && (dec_b.rd == 5'(r))) begin
        busy[r] <= lat_b;
      end else if (busy[r] != '0) begin
        busy[r] <= busy[r] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt <= '0;
    end else if (stall_en && (stall_cnt != STALL_MAX)) begin
      stall_cnt <= stall_cnt + STALL_W'(1);
    end
  end

  assign bus.issue_a_o   = issue_a;
  assign bus.issue_b_o   = issue_b;
  assign bus.stall_en_o  = stall_en;
  assign bus.stall_cnt_o = stall_cnt;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed-vector bench for issue_scoreboard with hand-computed grants and stall counts.
module tb_issue_scoreboard;

  logic clk;
  logic rst;
  int   nvec;
  int   nfail;
  logic [15:0] exp_cnt;

  issue_scoreboard_if bus ();

  issue_scoreboard #(
    .ALU_LAT (2),
    .LOAD_LAT(3),
    .CNT_W   (2)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] add(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [4:0] rs2);
    return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs1,
                                      input logic [11:0] imm);
    return {imm, rs1, 3'b010, rd, 7'b0000011};
  endfunction

  function automatic logic [31:0] sw(input logic [4:0] rs2, input logic [4:0] rs1,
                                      input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    nvec++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle: drive at the falling edge, sample before the next rising edge.
  task automatic step(input string tag,
                      input logic [31:0] a, input logic va,
                      input logic [31:0] b, input logic vb,
                      input logic p, input logic fl, input logic rs,
                      input logic eia, input logic eib, input logic est);
    @(negedge clk);
    bus.instr_a_i = a;
    bus.valid_a_i = va;
    bus.instr_b_i = b;
    bus.valid_b_i = vb;
    bus.prio_i    = p;
    bus.flush_i   = fl;
    rst           = rs;
    #2;
    check({tag, ".issue_a"},   16'(bus.issue_a_o),  16'(eia));
    check({tag, ".issue_b"},   16'(bus.issue_b_o),  16'(eib));
    check({tag, ".stall_en"},  16'(bus.stall_en_o), 16'(est));
    check({tag, ".stall_cnt"}, bus.stall_cnt_o,     exp_cnt);
    if (rs) exp_cnt = 16'h0000;
    else if (est && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
  endtask

  initial begin
    nvec    = 0;
    nfail   = 0;
    exp_cnt = 16'h0000;
    rst           = 1'b1;
    bus.instr_a_i = 32'h0;
    bus.valid_a_i = 1'b0;
    bus.instr_b_i = 32'h0;
    bus.valid_b_i = 1'b0;
    bus.prio_i    = 1'b0;
    bus.flush_i   = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Reset holds grants low even with a valid pair.
    step("rst", addi(1, 0, 5), 1, addi(2, 0, 7), 1, 0, 0, 1, 0, 0, 0);

    // Independent pair right after reset, then x1 busy for two cycles.
    step("pair",     addi(1, 0, 5), 1, addi(2, 0, 7), 1, 0, 0, 0, 1, 1, 0);
    step("x1_busy2", addi(11, 1, 0), 1, 32'h0, 0, 0, 0, 0, 0, 0, 1);
    step("x1_busy1", addi(11, 1, 0), 1, 32'h0, 0, 0, 0, 0, 0, 0, 1);
    step("x1_ready", addi(11, 1, 0), 1, 32'h0, 0, 0, 0, 0, 1, 0, 0);

    // Intra-pair RAW, then B waits out the ALU latency on its own.
    step("raw",    addi(3, 0, 1), 1, add(4, 3, 3), 1, 0, 0, 0, 1, 0, 1);
    step("raw_w1", 32'h0, 0, add(4, 3, 3), 1, 0, 0, 0, 0, 0, 1);
    step("raw_w2", 32'h0, 0, add(4, 3, 3), 1, 0, 0, 0, 0, 0, 1);
    step("raw_go", 32'h0, 0, add(4, 3, 3), 1, 0, 0, 0, 0, 1, 0);

    // Load-use: three cycles of LOAD_LAT.
    step("lw",     lw(5, 1, 0), 1, 32'h0, 0, 0, 0, 0, 1, 0, 0);
    step("lu_w1",  addi(6, 5, 1), 1, 32'h0, 0, 0, 0, 0, 0, 0, 1);
    step("lu_w2",  addi(6, 5, 1), 1, 32'h0, 0, 0, 0, 0, 0, 0, 1);
    step("lu_w3",  addi(6, 5, 1), 1, 32'h0, 0, 0, 0, 0, 0, 0, 1);
    step("lu_go",  addi(6, 5, 1), 1, 32'h0, 0, 0, 0, 0, 1, 0, 0);

    // Single LSU: only the older memory op issues, for either priority.
    step("lsu_p0", lw(7, 0, 0), 1, sw(8, 0, 4), 1, 0, 0, 0, 1, 0, 1);
    step("lsu_p1", lw(12, 0, 0), 1, sw(8, 0, 4), 1, 1, 0, 0, 0, 1, 1);

    // Older lane stalled blocks an independent younger lane.
    step("x9_set",  addi(9, 0, 3), 1, 32'h0, 0, 0, 0, 0, 1, 0, 0);
    step("inord_p0", addi(13, 9, 1), 1, addi(14, 0, 2), 1, 0, 0, 0, 0, 0, 1);
    step("inord_p1", addi(13, 9, 1), 1, addi(14, 0, 2), 1, 1, 0, 0, 0, 1, 1);

    // WAW on a shared rd, and x0 as destination creates no dependence.
    step("waw",     addi(15, 0, 1), 1, addi(15, 0, 2), 1, 0, 0, 0, 1, 0, 1);
    step("rd_x0",   addi(0, 0, 0), 1, addi(16, 0, 1), 1, 0, 0, 0, 1, 1, 0);
    step("raw_p1",  add(18, 17, 0), 1, addi(17, 0, 1), 1, 1, 0, 0, 0, 1, 1);

    // Flush kills the pair but counters keep running down.
    step("fl_set",  addi(1, 0, 5), 1, 32'h0, 0, 0, 0, 0, 1, 0, 0);
    step("flush",   addi(20, 0, 1), 1, addi(21, 0, 1), 1, 0, 1, 0, 0, 0, 0);
    step("fl_w1",   addi(22, 1, 0), 1, 32'h0, 0, 0, 0, 0, 0, 0, 1);
    step("fl_go",   addi(22, 1, 0), 1, 32'h0, 0, 0, 0, 0, 1, 0, 0);

    // Mid-run reset clears pending hazards and the stall counter.
    step("mr_set",  addi(1, 0, 5), 1, 32'h0, 0, 0, 0, 0, 1, 0, 0);
    step("mr_rst",  addi(1, 0, 5), 1, addi(2, 0, 7), 1, 0, 0, 1, 0, 0, 0);
    step("mr_go",   addi(23, 1, 0), 1, 32'h0, 0, 0, 0, 0, 1, 0, 0);

    // Continuous LSU stall long enough to saturate the counter.
    @(negedge clk);
    bus.instr_a_i = lw(24, 0, 0);
    bus.valid_a_i = 1'b1;
    bus.instr_b_i = sw(0, 0, 0);
    bus.valid_b_i = 1'b1;
    bus.prio_i    = 1'b0;
    bus.flush_i   = 1'b0;
    rst           = 1'b0;
    repeat (65540) @(negedge clk);
    exp_cnt = 16'hFFFF;
    step("sat",      lw(24, 0, 0), 1, sw(0, 0, 0), 1, 0, 0, 0, 1, 0, 1);
    step("sat_hold", lw(24, 0, 0), 1, sw(0, 0, 0), 1, 0, 0, 0, 1, 0, 1);
    step("sat_rst",  lw(24, 0, 0), 1, sw(0, 0, 0), 1, 0, 0, 1, 0, 0, 0);
    step("sat_clr",  32'h0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
